// File: rtl/stepper_sysid_reader.sv
// Avalon-MM read master that fetches the system-ID word (0) and build timestamp (1)
// and checks them against expected values for the stepper motor control logic.
`timescale 1ns/1ps
module stepper_sysid_reader #(
  parameter logic [31:0] EXPECTED_ID  = 32'h0400_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h5459_4CF2,
  parameter bit          CHECK_TS     = 1'b1,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 255,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timed_out,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned STALL_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned LAT_W    = 2;
  localparam int unsigned LAT_LAST = (READ_LATENCY == 0) ? 0 : READ_LATENCY - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ID, S_WAIT_ID, S_RD_TS, S_WAIT_TS, S_DONE
  } state_t;

  state_t               r_state, w_state;
  logic                 r_auto, w_auto;
  logic                 r_read, w_read;
  logic                 r_addr, w_addr;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic                 r_id_ok, w_id_ok;
  logic                 r_ts_ok, w_ts_ok;
  logic                 r_timed_out, w_timed_out;
  logic [31:0]          r_id_value, w_id_value;
  logic [31:0]          r_ts_value, w_ts_value;
  logic [STALL_W-1:0]   r_stall, w_stall;
  logic [LAT_W-1:0]     r_lat, w_lat;

  logic w_launch, w_accept, w_stall_hit, w_id_match, w_ts_match;

  assign w_launch    = start | r_auto;
  assign w_accept    = r_read & ~avm_waitrequest;
  assign w_stall_hit = r_read & avm_waitrequest & ((32'(r_stall) + 32'd1) >= TIMEOUT);
  assign w_id_match  = (avm_readdata == EXPECTED_ID);
  assign w_ts_match  = CHECK_TS ? (avm_readdata == EXPECTED_TS) : 1'b1;

  // Next-state and next-output logic; every output is a register fed from here.
  always_comb begin
    w_state     = r_state;
    w_auto      = 1'b0;
    w_read      = r_read;
    w_addr      = r_addr;
    w_busy      = r_busy;
    w_done      = r_done;
    w_id_ok     = r_id_ok;
    w_ts_ok     = r_ts_ok;
    w_timed_out = r_timed_out;
    w_id_value  = r_id_value;
    w_ts_value  = r_ts_value;
    w_stall     = r_stall;
    w_lat       = r_lat;

    // Stall accounting shared by both read phases; a stalled timeout aborts the sequence.
    if ((r_state == S_RD_ID || r_state == S_RD_TS) && r_read) begin
      if (w_accept) begin
        w_stall = '0;
      end else if (w_stall_hit) begin
        w_read      = 1'b0;
        w_stall     = '0;
        w_busy      = 1'b0;
        w_done      = 1'b1;
        w_timed_out = 1'b1;
        w_state     = S_DONE;
      end else if (32'(r_stall) < TIMEOUT) begin
        w_stall = r_stall + STALL_W'(1);
      end
    end

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_launch) begin
          w_done      = 1'b0;
          w_id_ok     = 1'b0;
          w_ts_ok     = 1'b0;
          w_timed_out = 1'b0;
          w_busy      = 1'b1;
          w_read      = 1'b1;
          w_addr      = 1'b0;
          w_stall     = '0;
          w_lat       = '0;
          w_state     = S_RD_ID;
        end
      end
      S_RD_ID: begin
        if (w_accept) begin
          w_read = 1'b0;
          if (READ_LATENCY == 0) begin
            w_id_value = avm_readdata;
            w_id_ok    = w_id_match;
            w_state    = S_RD_TS;
          end else begin
            w_lat   = '0;
            w_state = S_WAIT_ID;
          end
        end
      end
      S_WAIT_ID: begin
        if (32'(r_lat) == LAT_LAST) begin
          w_id_value = avm_readdata;
          w_id_ok    = w_id_match;
          w_lat      = '0;
          w_read     = 1'b1;
          w_addr     = 1'b1;
          w_state    = S_RD_TS;
        end else begin
          w_lat = r_lat + LAT_W'(1);
        end
      end
      S_RD_TS: begin
        // With zero latency this state is entered with read low, giving the mandatory gap cycle.
        if (!r_read) begin
          w_read = 1'b1;
          w_addr = 1'b1;
        end else if (w_accept) begin
          w_read = 1'b0;
          if (READ_LATENCY == 0) begin
            w_ts_value = avm_readdata;
            w_ts_ok    = w_ts_match;
            w_busy     = 1'b0;
            w_done     = 1'b1;
            w_state    = S_DONE;
          end else begin
            w_lat   = '0;
            w_state = S_WAIT_TS;
          end
        end
      end
      S_WAIT_TS: begin
        if (32'(r_lat) == LAT_LAST) begin
          w_ts_value = avm_readdata;
          w_ts_ok    = w_ts_match;
          w_lat      = '0;
          w_busy     = 1'b0;
          w_done     = 1'b1;
          w_state    = S_DONE;
        end else begin
          w_lat = r_lat + LAT_W'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_auto      <= AUTO_START;
      r_read      <= 1'b0;
      r_addr      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_id_ok     <= 1'b0;
      r_ts_ok     <= 1'b0;
      r_timed_out <= 1'b0;
      r_id_value  <= '0;
      r_ts_value  <= '0;
      r_stall     <= '0;
      r_lat       <= '0;
    end else begin
      r_state     <= w_state;
      r_auto      <= w_auto;
      r_read      <= w_read;
      r_addr      <= w_addr;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_id_ok     <= w_id_ok;
      r_ts_ok     <= w_ts_ok;
      r_timed_out <= w_timed_out;
      r_id_value  <= w_id_value;
      r_ts_value  <= w_ts_value;
      r_stall     <= w_stall;
      r_lat       <= w_lat;
    end
  end

  assign avm_read    = r_read;
  assign avm_address = r_addr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign timed_out   = r_timed_out;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_stepper_sysid_reader.sv
// Scoreboard bench: two readers (zero-latency defaults, and latency-2/timeout-4) against
// behavioural Avalon slaves; expected results come from a cycle-arithmetic model.
`timescale 1ns/1ps
module tb_stepper_sysid_reader;

  localparam int NDUT = 2;
  localparam logic [31:0] EID0 = 32'h0400_0000;
  localparam logic [31:0] ETS0 = 32'h5459_4CF2;
  localparam logic [31:0] EID1 = 32'h1234_5678;
  localparam logic [31:0] ETS1 = 32'hCAFE_F00D;

  typedef struct {
    logic [31:0] id_v;
    logic [31:0] ts_v;
    logic        id_ok;
    logic        ts_ok;
    logic        tmo;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NDUT-1:0]   start = '0;
  logic [NDUT-1:0]   wreq  = '0;
  logic [31:0]       rdata [NDUT];
  wire  [NDUT-1:0]   addr, read, busy, done, id_ok, ts_ok, tmo;
  wire  [31:0]       id_v [NDUT];
  wire  [31:0]       ts_v [NDUT];

  stepper_sysid_reader u_dut0 (
    .clock(clk), .reset_n(rst_n), .start(start[0]),
    .avm_address(addr[0]), .avm_read(read[0]), .avm_waitrequest(wreq[0]),
    .avm_readdata(rdata[0]), .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]),
    .ts_ok(ts_ok[0]), .timed_out(tmo[0]), .id_value(id_v[0]), .ts_value(ts_v[0])
  );

  stepper_sysid_reader #(
    .EXPECTED_ID(EID1), .EXPECTED_TS(ETS1), .CHECK_TS(1'b0),
    .READ_LATENCY(2), .TIMEOUT(4), .AUTO_START(1'b0)
  ) u_dut1 (
    .clock(clk), .reset_n(rst_n), .start(start[1]),
    .avm_address(addr[1]), .avm_read(read[1]), .avm_waitrequest(wreq[1]),
    .avm_readdata(rdata[1]), .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]),
    .ts_ok(ts_ok[1]), .timed_out(tmo[1]), .id_value(id_v[1]), .ts_value(ts_v[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        exp_q [NDUT][$];
  logic [31:0] mem_id [NDUT];
  logic [31:0] mem_ts [NDUT];
  int          st0 [NDUT];
  int          st1 [NDUT];
  logic [31:0] mdl_id [NDUT];
  logic [31:0] mdl_ts [NDUT];

  function automatic int lat_of(input int g);  return (g == 0) ? 0 : 2;   endfunction
  function automatic int tmo_of(input int g);  return (g == 0) ? 255 : 4; endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h (cycle %0d)", nm, g, act, want, cyc);
    end
  endtask

  // Reference model: outcome and completion cycle derived from stall counts and latency.
  function automatic exp_t model(input int g, input logic [31:0] id, input logic [31:0] ts,
                                 input int s0, input int s1, input int c);
    exp_t e;
    int L, T, d, a0, b1;
    L = lat_of(g);
    T = tmo_of(g);
    e.id_ok = 1'b0; e.ts_ok = 1'b0; e.tmo = 1'b0;
    if (s0 >= T) begin
      e.tmo = 1'b1;
      d = 1 + T;
    end else begin
      a0 = s0 + 1;
      mdl_id[g] = id;
      e.id_ok = (id == ((g == 0) ? EID0 : EID1));
      b1 = a0 + ((L == 0) ? 1 : L) + 1;
      if (s1 >= T) begin
        e.tmo = 1'b1;
        d = b1 + T;
      end else begin
        mdl_ts[g] = ts;
        e.ts_ok = (g == 0) ? (ts == ETS0) : 1'b1;
        d = b1 + s1 + L + 1;
      end
    end
    e.id_v = mdl_id[g];
    e.ts_v = mdl_ts[g];
    e.done_cyc = c + d;
    return e;
  endfunction

  // Behavioural slaves: programmable stall count per word, data valid exactly L cycles after accept.
  int          sl_cnt [NDUT];
  bit          pend [NDUT];
  int          pd [NDUT];
  logic        pa [NDUT];
  always @(negedge clk) begin
    logic [31:0] d;
    bit          have;
    for (int g = 0; g < NDUT; g++) begin
      have = 1'b0;
      d = '0;
      if (!rst_n) begin
        sl_cnt[g] = 0; pend[g] = 1'b0; wreq[g] = 1'b0;
      end else begin
        if (pend[g]) begin
          pd[g]--;
          if (pd[g] == 0) begin
            have = 1'b1; d = pa[g] ? mem_ts[g] : mem_id[g]; pend[g] = 1'b0;
          end
        end
        if (read[g]) begin
          if (sl_cnt[g] < (addr[g] ? st1[g] : st0[g])) begin
            wreq[g] = 1'b1; sl_cnt[g]++;
          end else begin
            wreq[g] = 1'b0; sl_cnt[g] = 0;
            if (lat_of(g) == 0) begin
              have = 1'b1; d = addr[g] ? mem_ts[g] : mem_id[g];
            end else begin
              pend[g] = 1'b1; pd[g] = lat_of(g); pa[g] = addr[g];
            end
          end
        end else begin
          wreq[g] = 1'b0; sl_cnt[g] = 0;
        end
      end
      rdata[g] = have ? d : $urandom;
    end
  end

  // Monitor: bus-rule checks every cycle, scoreboard pop on each rising done.
  int   m_nacc [NDUT];
  bit   m_pdone [NDUT];
  bit   m_pbusy [NDUT];
  bit   m_pacc [NDUT];
  bit   m_pread [NDUT];
  logic m_paddr [NDUT];
  always begin
    exp_t e;
    bit   acc;
    @(negedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      if (!rst_n) begin
        m_pdone[g] = 1'b0; m_pbusy[g] = 1'b0; m_pacc[g] = 1'b0; m_pread[g] = 1'b0; m_nacc[g] = 0;
      end else begin
        if (busy[g] && !m_pbusy[g]) m_nacc[g] = 0;
        acc = read[g] && !wreq[g];
        if (m_pacc[g]) chk("gap_after_accept", g, 32'(read[g]), 32'd0);
        if (read[g] && m_pread[g] && !m_pacc[g]) chk("addr_stable", g, 32'(addr[g]), 32'(m_paddr[g]));
        if (acc) begin
          chk("accept_addr", g, 32'(addr[g]), 32'(m_nacc[g]));
          m_nacc[g]++;
        end
        if (done[g] && !m_pdone[g]) begin
          if (exp_q[g].size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done dut%0d: got done=1 want no sequence (cycle %0d)", g, cyc);
          end else begin
            e = exp_q[g].pop_front();
            chk("id_value", g, id_v[g], e.id_v);
            chk("ts_value", g, ts_v[g], e.ts_v);
            chk("id_ok", g, 32'(id_ok[g]), 32'(e.id_ok));
            chk("ts_ok", g, 32'(ts_ok[g]), 32'(e.ts_ok));
            chk("timed_out", g, 32'(tmo[g]), 32'(e.tmo));
            chk("done_cycle", g, 32'(cyc), 32'(e.done_cyc));
            chk("busy_at_done", g, 32'(busy[g]), 32'd0);
          end
        end
        m_pdone[g] = done[g]; m_pbusy[g] = busy[g]; m_pacc[g] = acc;
        m_pread[g] = read[g]; m_paddr[g] = addr[g];
      end
    end
  end

  task automatic issue(input int g, input logic [31:0] id, input logic [31:0] ts, input int s0, input int s1);
    mem_id[g] = id; mem_ts[g] = ts; st0[g] = s0; st1[g] = s1;
    @(negedge clk);
    exp_q[g].push_back(model(g, id, ts, s0, s1, cyc));
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (exp_q[g].size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q[g].size() != 0) begin
      total++; bad++;
      $display("FAIL seq_timeout dut%0d: got %0d pending want 0", g, exp_q[g].size());
      exp_q[g].delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_cleared(input string nm, input int g);
    chk({nm, "_read"}, g, 32'(read[g]), 32'd0);
    chk({nm, "_busy"}, g, 32'(busy[g]), 32'd0);
    chk({nm, "_done"}, g, 32'(done[g]), 32'd0);
    chk({nm, "_flags"}, g, {29'd0, id_ok[g], ts_ok[g], tmo[g]}, 32'd0);
    chk({nm, "_vals"}, g, id_v[g] | ts_v[g] | 32'(addr[g]), 32'd0);
  endtask

  initial begin
    int g, s0, s1;
    logic [31:0] id, ts, eid, ets;
    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      mdl_id[i] = '0; mdl_ts[i] = '0; st0[i] = 0; st1[i] = 0;
    end
    mem_id[0] = EID0; mem_ts[0] = ETS0;
    mem_id[1] = EID1; mem_ts[1] = ETS1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) chk_cleared("reset", i);

    // Auto-start sequence after release on the zero-wait default reader.
    exp_q[0].push_back(model(0, EID0, ETS0, 0, 0, cyc));
    rst_n = 1'b1;
    wait_idle(0);
    chk("no_auto_on_dut1", 1, 32'(busy[1] | done[1]), 32'd0);

    issue(0, EID0 + 32'd1, ETS0, 0, 0);       wait_idle(0);
    issue(0, EID0, ETS0 ^ 32'h8000_0000, 1, 2); wait_idle(0);
    issue(1, EID1, ETS1, 3, 3);               wait_idle(1);
    issue(1, EID1, 32'h1111_2222, 0, 4);      wait_idle(1);
    issue(1, EID1 ^ 32'h10, ETS1, 9, 0);      wait_idle(1);
    issue(0, EID0, ETS0, 254, 255);           wait_idle(0);

    // start pulses while busy are ignored; one completion only.
    issue(1, EID1, 32'h0BAD_0BAD, 3, 3);
    start[1] = 1'b1; @(negedge clk); start[1] = 1'b0;
    repeat (4) @(negedge clk);
    start[1] = 1'b1; @(negedge clk); start[1] = 1'b0;
    wait_idle(1);
    repeat (5) @(negedge clk);
    chk("busy_after_ignored_start", 1, 32'(busy[1]), 32'd0);
    chk("done_held", 1, 32'(done[1]), 32'd1);

    // start sampled on the edge that enters DONE is dropped.
    issue(0, EID0, ETS0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    wait_idle(0);
    repeat (3) @(negedge clk);
    chk("no_relaunch_busy", 0, 32'(busy[0]), 32'd0);
    chk("no_relaunch_done", 0, 32'(done[0]), 32'd1);

    for (int k = 0; k < 24; k++) begin
      g   = int'($urandom_range(0, 1));
      eid = (g == 0) ? EID0 : EID1;
      ets = (g == 0) ? ETS0 : ETS1;
      id  = ($urandom_range(0, 1) == 0) ? eid : eid ^ (32'd1 << $urandom_range(0, 31));
      ts  = ($urandom_range(0, 1) == 0) ? ets : $urandom;
      s0  = int'($urandom_range(0, 3));
      s1  = int'($urandom_range(0, 3));
      if (g == 1 && $urandom_range(0, 3) == 0) s0 = int'($urandom_range(4, 6));
      if (g == 1 && $urandom_range(0, 3) == 0) s1 = int'($urandom_range(4, 6));
      issue(g, id, ts, s0, s1);
      wait_idle(g);
    end

    // Asynchronous reset while a read is outstanding.
    issue(1, EID1, ETS1, 3, 3);
    chk("pre_reset_read", 1, 32'(read[1]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) chk_cleared("async_reset", i);
    exp_q[1].delete();
    for (int i = 0; i < NDUT; i++) begin
      mdl_id[i] = '0; mdl_ts[i] = '0;
    end
    mem_id[0] = EID0; mem_ts[0] = ETS0; st0[0] = 2; st1[0] = 1;
    @(negedge clk);
    @(negedge clk);
    exp_q[0].push_back(model(0, EID0, ETS0, 2, 1, cyc));
    rst_n = 1'b1;
    wait_idle(0);
    issue(1, EID1, ETS1, 1, 2);
    wait_idle(1);

    for (int i = 0; i < NDUT; i++) chk("queue_drained", i, 32'(exp_q[i].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish by 500000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
